adder_tree_seq: RTL and testbench

//  Sequencer/accumulator controller for the shared combinational carry-save adder tree (N_INPUTS x INPUT_WIDTH -> OUT0/OUT1).

---
 rtl/adder_tree_seq_if.sv | 32 +++
 rtl/adder_tree_seq.sv | 134 +++++++++++++
 tb/tb_adder_tree_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/adder_tree_seq_if.sv
// Handshake bundle between the adder-tree sequencer and its surroundings:
// start/length control, beat stream in, operands/partials to the tree, result out.
interface adder_tree_seq_if #(
  parameter int N_INPUTS    = 8,
  parameter int INPUT_WIDTH = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int CNT_WIDTH   = 8
);
  logic                            start;
  logic [CNT_WIDTH-1:0]            cfg_len;
  logic                            busy;
  logic                            in_valid;
  logic                            in_ready;
  logic [N_INPUTS*INPUT_WIDTH-1:0] in_data;
  logic [N_INPUTS*INPUT_WIDTH-1:0] tree_in;
  logic [INPUT_WIDTH-1:0]          tree_out0;
  logic [INPUT_WIDTH-1:0]          tree_out1;
  logic                            out_valid;
  logic                            out_ready;
  logic [ACC_WIDTH-1:0]            out_sum;
  logic                            out_ovf;

  modport master (
    output start, cfg_len, in_valid, in_data, tree_out0, tree_out1, out_ready,
    input  busy, in_ready, tree_in, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  start, cfg_len, in_valid, in_data, tree_out0, tree_out1, out_ready,
    output busy, in_ready, tree_in, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/adder_tree_seq.sv
// Streams cfg_len beats through a shared carry-save adder tree and accumulates OUT0+OUT1.
// Define ADDER_TREE_SEQ_SAT_EN for a saturating accumulator with sticky out_ovf; otherwise it wraps.
module adder_tree_seq #(
  parameter int N_INPUTS    = 8,
  parameter int INPUT_WIDTH = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int CNT_WIDTH   = 8
) (
  input logic              clk,
  input logic              rst_n,
  adder_tree_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

`ifdef ADDER_TREE_SEQ_SAT_EN
  localparam int SUM_W = ACC_WIDTH + 1;
`else
  localparam int SUM_W = ACC_WIDTH;
`endif

  state_t                          state_q;
  logic                            busy_q;
  logic                            in_ready_q;
  logic                            out_valid_q;
  logic                            s1_vld_q;
  logic [N_INPUTS*INPUT_WIDTH-1:0] tree_in_q;
  logic [ACC_WIDTH-1:0]            acc_q;
  logic [CNT_WIDTH-1:0]            count_q;
  logic [CNT_WIDTH-1:0]            len_q;
`ifdef ADDER_TREE_SEQ_SAT_EN
  logic                            ovf_q;
`endif

  logic [INPUT_WIDTH-1:0]          tree_sum;
  logic [SUM_W-1:0]                acc_sum;
  logic [ACC_WIDTH-1:0]            acc_d;
  logic                            beat_hs;

  // Tree partials resolved modulo 2^INPUT_WIDTH before zero-extension into the accumulator.
  always_comb begin
    tree_sum = bus.tree_out0 + bus.tree_out1;
    acc_sum  = {{(SUM_W-ACC_WIDTH){1'b0}}, acc_q}
             + {{(SUM_W-INPUT_WIDTH){1'b0}}, tree_sum};
`ifdef ADDER_TREE_SEQ_SAT_EN
    acc_d    = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
`else
    acc_d    = acc_sum;
`endif
    beat_hs  = bus.in_valid & in_ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      tree_in_q   <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
`ifdef ADDER_TREE_SEQ_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_vld_q <= 1'b0;
      if (s1_vld_q) begin
        acc_q <= acc_d;
`ifdef ADDER_TREE_SEQ_SAT_EN
        if (acc_sum[ACC_WIDTH]) ovf_q <= 1'b1;
`endif
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= bus.cfg_len;
            busy_q  <= 1'b1;
`ifdef ADDER_TREE_SEQ_SAT_EN
            ovf_q   <= 1'b0;
`endif
            if (bus.cfg_len != '0) begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat_hs) begin
            tree_in_q <= bus.in_data;
            s1_vld_q  <= 1'b1;
            count_q   <= count_q + 1'b1;
            if (count_q == len_q - 1'b1) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        // Last operand is in the tree this cycle; its sum lands in acc at this edge.
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.tree_in   = tree_in_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
`ifdef ADDER_TREE_SEQ_SAT_EN
  assign bus.out_ovf   = ovf_q;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_adder_tree_seq.sv
// Self-checking bench for adder_tree_seq: directed scenarios plus randomized sums vs. an arithmetic model.
// Uses ACC_WIDTH=12 so wrap/saturation is reachable; honours ADDER_TREE_SEQ_SAT_EN.
module tb_adder_tree_seq;
  localparam int N   = 8;
  localparam int W   = 8;
  localparam int ACC = 12;
  localparam int CW  = 8;
  localparam int ACC_MAX = (1 << ACC) - 1;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic split_mode;
  logic [W-1:0] split_r;

  adder_tree_seq_if #(.N_INPUTS(N), .INPUT_WIDTH(W), .ACC_WIDTH(ACC), .CNT_WIDTH(CW)) bus ();

  adder_tree_seq #(.N_INPUTS(N), .INPUT_WIDTH(W), .ACC_WIDTH(ACC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) split_r <= W'($urandom);

  // Tree model: plain lane sum, optionally split randomly between the two partials.
  always_comb begin
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + bus.tree_in[i*W +: W];
    bus.tree_out1 = split_mode ? split_r : '0;
    bus.tree_out0 = s - bus.tree_out1;
  end

  function automatic int lane_sum(input logic [N*W-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(d[i*W +: W]);
    return s % (1 << W);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete sum. lane_val<0 -> random lanes. noise -> stray start pulses while busy.
  task automatic do_sum(input int len, input int lane_val, input int gap_pct,
                        input int hold, input bit noise);
    int acc_m;
    bit ovf_m;
    logic [N*W-1:0] d;
    acc_m = 0;
    ovf_m = 1'b0;
    bus.start   = 1'b1;
    bus.cfg_len = CW'(len);
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    if (len == 0) begin
      chk("zero_len_valid", 32'(bus.out_valid), 32'd1);
      chk("zero_len_sum", 32'(bus.out_sum), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = '1;
    end else begin
      for (int b = 0; b < len; b++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          bus.in_valid = 1'b0;
          bus.in_data  = {N*W{1'b1}};
          if (noise) begin bus.start = 1'b1; bus.cfg_len = 8'd2; end
          tick();
        end
        bus.start = 1'b0;
        for (int i = 0; i < N; i++)
          d[i*W +: W] = (lane_val < 0) ? W'($urandom) : W'(lane_val);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        chk("in_ready_accum", 32'(bus.in_ready), 32'd1);
        tick();
        chk("tree_in_lane0", 32'(bus.tree_in[W-1:0]), 32'(d[W-1:0]));
        acc_m += lane_sum(d);
        if (acc_m > ACC_MAX) begin
`ifdef ADDER_TREE_SEQ_SAT_EN
          acc_m = ACC_MAX;
          ovf_m = 1'b1;
`else
          acc_m = acc_m - (ACC_MAX + 1);
`endif
        end
      end
      bus.in_valid = 1'b0;
      chk("drain_no_valid", 32'(bus.out_valid), 32'd0);
      chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("latency_valid", 32'(bus.out_valid), 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      if (noise) begin bus.start = 1'b1; bus.cfg_len = 8'd0; end
      tick();
    end
    bus.start = 1'b0;
    chk("done_valid_held", 32'(bus.out_valid), 32'd1);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("out_sum", 32'(bus.out_sum), 32'(acc_m));
    chk("out_ovf", 32'(bus.out_ovf), 32'(ovf_m));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("after_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("after_hs_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    split_mode    = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_tree_in", bus.tree_in[31:0], 32'd0);
    rst_n = 1'b1;
    tick();

    do_sum(3, 1, 0, 0, 1'b0);            // expects 24
    do_sum(4, 31, 40, 5, 1'b0);          // expects 992, held through stall
    do_sum(0, 0, 0, 2, 1'b0);            // empty sum
    do_sum(17, 31, 0, 0, 1'b0);          // overflow: 4095/1 or 120/0
    do_sum(5, -1, 30, 3, 1'b1);          // stray starts ignored

    // Mid-operation reset after two of five beats.
    bus.start = 1'b1; bus.cfg_len = 8'd5;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = {N{8'd9}};
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("midrst_tree_in", bus.tree_in[31:0], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_sum(1, 2, 0, 0, 1'b0);            // expects 16

    split_mode = 1'b1;
    for (int r = 0; r < 10; r++)
      do_sum(int'($urandom_range(40, 1)), -1, 25, int'($urandom_range(3)), r[0]);
    do_sum(17, 31, 10, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
